strobe_cmd_sched: RTL and testbench

//  Round-robin scheduler that shares the block's command/opcode/async_strobe

---
 rtl/strobe_cmd_sched.sv | 193 +++++++++++++++++++
 tb/tb_strobe_cmd_sched.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/strobe_cmd_sched.sv
// -----------------------------------------------------------------------------
// strobe_cmd_sched
//   Round-robin scheduler that shares the block's command/opcode/async_strobe
//   port between N_REQ requesters. The winner's 20-bit command and 3-bit
//   opcode are latched, then async_strobe is driven with fixed setup / pulse /
//   hold spacing so the block's asynchronous capture sees stable data.
//
//   Optional feature macro: STROBE_CMD_SCHED_PRIORITY_EN
//     defined   -> requester 0 has strict priority and does not move the
//                  round-robin pointer; requesters 1..N_REQ-1 rotate.
//     undefined -> pure round-robin over all requesters.
//
// Ports
//   i_clk            clock
//   i_rst            synchronous reset, active-high
//   i_req            per-requester level request, held until granted
//   i_req_command    command of requester i at [20*i +: 20]
//   i_req_opcode     opcode of requester i at [3*i +: 3]
//   o_grant          one-hot, one-cycle pulse when a request is accepted
//   o_command        to block.command
//   o_opcode         to block.opcode
//   o_async_strobe   to block.async_strobe
//   o_busy           high from grant until the sequencer is back in IDLE
// -----------------------------------------------------------------------------
module strobe_cmd_sched #(
    parameter int N_REQ         = 4,
    parameter int SETUP_CYCLES  = 5,
    parameter int STROBE_CYCLES = 5,
    parameter int HOLD_CYCLES   = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [20*N_REQ-1:0]  i_req_command,
    input  logic [3*N_REQ-1:0]   i_req_opcode,
    output logic [N_REQ-1:0]     o_grant,
    output logic [19:0]          o_command,
    output logic [2:0]           o_opcode,
    output logic                 o_async_strobe,
    output logic                 o_busy
);

    localparam int MAX_ST = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_C  = (MAX_ST > HOLD_CYCLES) ? MAX_ST : HOLD_CYCLES;
    localparam int CW     = $clog2(MAX_C + 1);
    localparam int PW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;

`ifdef STROBE_CMD_SCHED_PRIORITY_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic [PW-1:0]      r_rr_ptr, w_rr_ptr_nxt;
    logic [N_REQ-1:0]   r_grant, w_grant_nxt;
    logic [19:0]        r_command, w_command_nxt;
    logic [2:0]         r_opcode, w_opcode_nxt;
    logic               r_async_strobe, w_async_strobe_nxt;
    logic               r_busy, w_busy_nxt;

    // Arbitration results
    logic               w_found;
    logic               w_adv_ptr;
    logic [PW-1:0]      w_sel;
    logic [N_REQ-1:0]   w_sel_oh;
    logic [19:0]        w_sel_cmd;
    logic [2:0]         w_sel_op;
    int                 w_dist;
    int                 w_best_dist;

    // Winner = requesting index with the smallest forward distance from
    // rr_ptr. With priority enabled, index 0 is excluded from the rotation
    // and instead overrides it without advancing the pointer.
    always_comb begin
        w_found     = 1'b0;
        w_adv_ptr   = 1'b0;
        w_sel       = '0;
        w_sel_oh    = '0;
        w_sel_cmd   = '0;
        w_sel_op    = '0;
        w_dist      = 0;
        w_best_dist = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            w_dist = (i + N_REQ - int'(r_rr_ptr)) % N_REQ;
            if (i_req[i] && !(PRIO_EN && i == 0) && w_dist < w_best_dist) begin
                w_found     = 1'b1;
                w_adv_ptr   = 1'b1;
                w_best_dist = w_dist;
                w_sel       = PW'(i);
                w_sel_oh    = '0;
                w_sel_oh[i] = 1'b1;
                w_sel_cmd   = i_req_command[20*i +: 20];
                w_sel_op    = i_req_opcode[3*i +: 3];
            end
        end
        if (PRIO_EN && i_req[0]) begin
            w_found     = 1'b1;
            w_adv_ptr   = 1'b0;
            w_sel       = '0;
            w_sel_oh    = '0;
            w_sel_oh[0] = 1'b1;
            w_sel_cmd   = i_req_command[19:0];
            w_sel_op    = i_req_opcode[2:0];
        end
    end

    // Next-state and registered-output values. The counter is loaded with
    // (phase length - 1) on entry so the exit edge is the one seeing zero.
    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_rr_ptr_nxt       = r_rr_ptr;
        w_grant_nxt        = '0;
        w_command_nxt      = r_command;
        w_opcode_nxt       = r_opcode;
        w_async_strobe_nxt = r_async_strobe;
        w_busy_nxt         = r_busy;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grant_nxt   = w_sel_oh;
                    w_command_nxt = w_sel_cmd;
                    w_opcode_nxt  = w_sel_op;
                    w_busy_nxt    = 1'b1;
                    w_cnt_nxt     = CW'(SETUP_CYCLES - 1);
                    w_state_nxt   = SETUP;
                    if (w_adv_ptr)
                        w_rr_ptr_nxt = PW'((int'(w_sel) + 1) % N_REQ);
                end
            end
            SETUP: begin
                if (r_cnt == '0) begin
                    w_async_strobe_nxt = 1'b1;
                    w_cnt_nxt          = CW'(STROBE_CYCLES - 1);
                    w_state_nxt        = PULSE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            PULSE: begin
                if (r_cnt == '0) begin
                    w_async_strobe_nxt = 1'b0;
                    w_cnt_nxt          = CW'(HOLD_CYCLES - 1);
                    w_state_nxt        = HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            HOLD: begin
                if (r_cnt == '0) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_rr_ptr       <= '0;
            r_grant        <= '0;
            r_command      <= '0;
            r_opcode       <= '0;
            r_async_strobe <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_rr_ptr       <= w_rr_ptr_nxt;
            r_grant        <= w_grant_nxt;
            r_command      <= w_command_nxt;
            r_opcode       <= w_opcode_nxt;
            r_async_strobe <= w_async_strobe_nxt;
            r_busy         <= w_busy_nxt;
        end
    end

    assign o_grant        = r_grant;
    assign o_command      = r_command;
    assign o_opcode       = r_opcode;
    assign o_async_strobe = r_async_strobe;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_strobe_cmd_sched.sv
// -----------------------------------------------------------------------------
// tb_strobe_cmd_sched
//   Self-checking bench for strobe_cmd_sched at default parameters.
//   Directed table of single-command records, hand sequences for reset,
//   back-to-back rotation, mid-command reset and withdrawn requests, then
//   randomized traffic against a timeline-level reference model.
// -----------------------------------------------------------------------------
module tb_strobe_cmd_sched;

    localparam int N   = 4;
    localparam int S   = 5;
    localparam int T   = 5;
    localparam int H   = 5;
    localparam int PER = 1 + S + T + H;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [20*N-1:0]  req_cmd;
    logic [3*N-1:0]   req_op;
    logic [N-1:0]     grant;
    logic [19:0]      command;
    logic [2:0]       opcode;
    logic             strobe;
    logic             busy;

    int n_checks = 0;
    int n_err    = 0;

    localparam logic [20*N-1:0] STD_CMD = {20'heb852, 20'h97531, 20'hcdef0, 20'h6789a};
    localparam logic [3*N-1:0]  STD_OP  = {3'd2, 3'd7, 3'd6, 3'd5};

    strobe_cmd_sched #(
        .N_REQ(N), .SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .i_req_command(req_cmd), .i_req_opcode(req_op),
        .o_grant(grant), .o_command(command), .o_opcode(opcode),
        .o_async_strobe(strobe), .o_busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Tracks only "active" and cycles elapsed since the grant edge; the
    // output waveform is a function of that elapsed count.
    function automatic int pick(input logic [N-1:0] r, input int ptr);
`ifdef STROBE_CMD_SCHED_PRIORITY_EN
        if (r[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            int idx = (ptr + k) % N;
`ifdef STROBE_CMD_SCHED_PRIORITY_EN
            if (idx != 0 && r[idx]) return idx;
`else
            if (r[idx]) return idx;
`endif
        end
        return -1;
    endfunction

    logic         m_act;
    int           m_t, m_ptr, m_win;
    logic [N-1:0] m_grant;
    logic [19:0]  m_cmd;
    logic [2:0]   m_op;
    logic         m_strb, m_busy;

    always_comb m_win = pick(req, m_ptr);

    always @(posedge clk) begin
        if (rst) begin
            m_act <= 1'b0; m_t <= 0; m_ptr <= 0; m_grant <= '0;
            m_cmd <= '0; m_op <= '0; m_strb <= 1'b0; m_busy <= 1'b0;
        end else if (!m_act) begin
            m_grant <= '0;
            if (m_win >= 0) begin
                m_act   <= 1'b1;
                m_t     <= 0;
                m_grant <= N'(1) << m_win;
                m_cmd   <= req_cmd[20*m_win +: 20];
                m_op    <= req_op[3*m_win +: 3];
                m_busy  <= 1'b1;
                m_strb  <= 1'b0;
`ifdef STROBE_CMD_SCHED_PRIORITY_EN
                if (m_win != 0) m_ptr <= (m_win + 1) % N;
`else
                m_ptr <= (m_win + 1) % N;
`endif
            end
        end else begin
            m_grant <= '0;
            m_t     <= m_t + 1;
            m_strb  <= (m_t + 1 >= S) && (m_t + 1 < S + T);
            if (m_t + 1 == S + T + H) begin
                m_act  <= 1'b0;
                m_busy <= 1'b0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic get_grant(output logic [N-1:0] g, output int dt);
        g  = '0;
        dt = 0;
        for (int c = 1; c <= 2*PER; c++) begin
            tick();
            if (grant != '0) begin
                g  = grant;
                dt = c;
                break;
            end
        end
    endtask

    task automatic wait_idle;
        for (int c = 0; c < 2*PER && busy !== 1'b0; c++) tick();
        chk("wait_idle", 32'(busy), 32'd0);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = '0;
        tick(); tick(); tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0]    req;
        logic [20*N-1:0] cmds;
        logic [3*N-1:0]  ops;
        logic [N-1:0]    exp_grant;
        logic [19:0]     exp_cmd;
        logic [2:0]      exp_op;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [N-1:0] g;
        int           dt, bad, saw;
        logic [N-1:0] exp_seq[5];
        logic [19:0]  cmd0;

        rst = 1'b1; req = '0; req_cmd = STD_CMD; req_op = STD_OP;

        // ---- reset state ----
        do_reset();
        rst = 1'b1;
        tick();
        chk("rst_grant",   32'(grant),   32'd0);
        chk("rst_command", 32'(command), 32'd0);
        chk("rst_opcode",  32'(opcode),  32'd0);
        chk("rst_strobe",  32'(strobe),  32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        rst = 1'b0;

        // ---- table of single commands (pointer starts at 0) ----
        tbl[0] = '{4'b0100, {20'h0, 20'h12345, 20'h0, 20'h0}, {3'd0, 3'd1, 3'd0, 3'd0}, 4'b0100, 20'h12345, 3'd1};
`ifdef STROBE_CMD_SCHED_PRIORITY_EN
        tbl[1] = '{4'b1111, STD_CMD, STD_OP, 4'b0001, 20'h6789a, 3'd5};
        tbl[2] = '{4'b1111, STD_CMD, STD_OP, 4'b0001, 20'h6789a, 3'd5};
        tbl[3] = '{4'b1111, STD_CMD, STD_OP, 4'b0001, 20'h6789a, 3'd5};
        tbl[4] = '{4'b1111, STD_CMD, STD_OP, 4'b0001, 20'h6789a, 3'd5};
`else
        tbl[1] = '{4'b1111, STD_CMD, STD_OP, 4'b1000, 20'heb852, 3'd2};
        tbl[2] = '{4'b1111, STD_CMD, STD_OP, 4'b0001, 20'h6789a, 3'd5};
        tbl[3] = '{4'b1111, STD_CMD, STD_OP, 4'b0010, 20'hcdef0, 3'd6};
        tbl[4] = '{4'b1111, STD_CMD, STD_OP, 4'b0100, 20'h97531, 3'd7};
`endif
        tbl[5] = '{4'b0011, STD_CMD, STD_OP, 4'b0001, 20'h6789a, 3'd5};
        tbl[6] = '{4'b0001, STD_CMD, STD_OP, 4'b0001, 20'h6789a, 3'd5};
        tbl[7] = '{4'b1000, STD_CMD, STD_OP, 4'b1000, 20'heb852, 3'd2};

        for (int v = 0; v < 8; v++) begin
            req_cmd = tbl[v].cmds;
            req_op  = tbl[v].ops;
            req     = tbl[v].req;
            get_grant(g, dt);
            req = '0;
            chk($sformatf("vec%0d_latency", v), 32'(dt), 32'd1);
            chk($sformatf("vec%0d_grant", v), 32'(g), 32'(tbl[v].exp_grant));
            chk($sformatf("vec%0d_command", v), 32'(command), 32'(tbl[v].exp_cmd));
            chk($sformatf("vec%0d_opcode", v), 32'(opcode), 32'(tbl[v].exp_op));
            bad = -1;
            for (int t = 1; t <= S + T + H; t++) begin
                tick();
                if (bad < 0 && (strobe !== ((t >= S) && (t < S + T)) ||
                                busy !== (t < S + T + H) || grant !== '0 ||
                                command !== tbl[v].exp_cmd))
                    bad = t;
            end
            chk($sformatf("vec%0d_timing_bad_t", v), 32'(bad), 32'hffffffff);
        end

        // ---- all requesters held: rotation and 16-cycle spacing ----
        do_reset();
        req_cmd = STD_CMD; req_op = STD_OP;
`ifdef STROBE_CMD_SCHED_PRIORITY_EN
        exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            get_grant(g, dt);
            chk($sformatf("rr%0d_grant", k), 32'(g), 32'(exp_seq[k]));
            chk($sformatf("rr%0d_spacing", k), 32'(dt), (k == 0) ? 32'd1 : 32'(PER));
            if (k == 1)
                chk("rr1_command", 32'(command), 32'(exp_seq[1] == 4'b0010 ? 20'hcdef0 : 20'h6789a));
        end
        req = '0;
        wait_idle();

        // ---- reset during PULSE ----
        do_reset();
        req = 4'b0001;
        get_grant(g, dt);
        chk("rstp_first_grant", 32'(g), 32'h1);
        req = 4'b0010;
        for (int c = 0; c < PER && strobe !== 1'b1; c++) tick();
        chk("rstp_in_pulse", 32'(strobe), 32'd1);
        rst = 1'b1;
        tick();
        chk("rstp_strobe", 32'(strobe), 32'd0);
        chk("rstp_busy", 32'(busy), 32'd0);
        chk("rstp_command", 32'(command), 32'd0);
        chk("rstp_grant", 32'(grant), 32'd0);
        rst = 1'b0;
        tick();
        chk("rstp_regrant", 32'(grant), 32'h2);
        chk("rstp_regrant_cmd", 32'(command), 32'hcdef0);
        req = '0;
        wait_idle();

        // ---- request withdrawn during another command's HOLD ----
        do_reset();
        req = 4'b0001;
        get_grant(g, dt);
        req = '0;
        cmd0 = command;
        chk("wd_cmd0", 32'(cmd0), 32'h6789a);
        for (int c = 0; c < PER && strobe !== 1'b1; c++) tick();
        for (int c = 0; c < PER && strobe !== 1'b0; c++) tick();
        req_cmd[39:20] = 20'haaaaa;
        req = 4'b0010;
        tick(); tick();
        req = '0;
        saw = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (grant !== '0 || command !== cmd0) saw = 1;
        end
        chk("wd_no_grant", 32'(saw), 32'd0);
        req_cmd = STD_CMD;

`ifdef STROBE_CMD_SCHED_PRIORITY_EN
        // ---- strict priority for requester 0 ----
        do_reset();
        req = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            get_grant(g, dt);
            chk($sformatf("prio%0d_grant", k), 32'(g), 32'h1);
        end
        req = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            get_grant(g, dt);
            chk($sformatf("prio_rr%0d_grant", k), 32'(g), (k % 2 == 0) ? 32'h2 : 32'h8);
        end
        req = '0;
        wait_idle();
`endif

        // ---- randomized traffic vs reference model ----
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            chk("rnd_grant",   32'(grant),   32'(m_grant));
            chk("rnd_command", 32'(command), 32'(m_cmd));
            chk("rnd_opcode",  32'(opcode),  32'(m_op));
            chk("rnd_strobe",  32'(strobe),  32'(m_strb));
            chk("rnd_busy",    32'(busy),    32'(m_busy));
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if (m_grant[i]) begin
                    req[i] = 1'($urandom_range(0, 1));
                    req_cmd[20*i +: 20] = 20'($urandom);
                    req_op[3*i +: 3]    = 3'($urandom);
                end else if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                        req_cmd[20*i +: 20] = 20'($urandom);
                        req_op[3*i +: 3]    = 3'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
